// File: rtl/gps_pkg.sv
// ============================================================================
// Module      : gps_pkg
// Description : Shared widths and sample type for the GPS I/Q output path.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package gps_pkg;

    localparam int SAMPLE_W       = 3;
    localparam int LANES_PER_WORD = 5;
    localparam int WORD_W         = 32;
    localparam int SEQ_W          = 2;
    localparam int LANE_W         = 2 * SAMPLE_W;
    localparam int PAYLOAD_W      = LANES_PER_WORD * LANE_W;

    // Packed so that the struct value is exactly one lane: imag high, real low.
    typedef struct packed {
        logic [SAMPLE_W-1:0] imag_part;
        logic [SAMPLE_W-1:0] real_part;
    } iq_sample_t;

endpackage

`default_nettype wire

// File: rtl/gps_sync_fifo.sv
// ============================================================================
// Module      : gps_sync_fifo
// Description : Single-clock first-word-fall-through FIFO with registered
//               output stage; count includes the word on the output.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module gps_sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_wr_en,
    input  logic [WIDTH-1:0]         i_wr_data,
    input  logic                     i_rd_en,
    output logic [WIDTH-1:0]         o_rd_data,
    output logic                     o_rd_valid,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int                  c_ptr_w   = $clog2(DEPTH);
    localparam int                  c_cnt_w   = c_ptr_w + 1;
    localparam logic [c_ptr_w-1:0]  c_ptr_one = c_ptr_w'(1);
    localparam logic [c_cnt_w-1:0]  c_depth   = c_cnt_w'(DEPTH);

    logic [WIDTH-1:0]    r_mem [DEPTH];
    logic [c_ptr_w-1:0]  r_wr_ptr;
    logic [c_ptr_w-1:0]  r_rd_ptr;
    logic [c_cnt_w-1:0]  r_mem_cnt;
    logic [c_cnt_w-1:0]  r_count;
    logic                r_valid;
    logic [WIDTH-1:0]    r_dout;

    logic w_full;
    logic w_pop;
    logic w_push;
    logic w_load;

    assign w_full = (r_count == c_depth);
    assign w_pop  = r_valid & i_rd_en;
    // A pop on a full FIFO frees the slot in the same cycle.
    assign w_push = i_wr_en & (~w_full | w_pop);
    // The output stage refills only from stored words, never bypassing.
    assign w_load = (r_mem_cnt != '0) & (~r_valid | w_pop);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_mem_cnt <= '0;
            r_count   <= '0;
            r_valid   <= 1'b0;
            r_dout    <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_load) begin
                r_dout   <= r_mem[r_rd_ptr];
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
                r_valid  <= 1'b1;
            end else if (w_pop) begin
                r_valid  <= 1'b0;
            end
            r_mem_cnt <= r_mem_cnt + c_cnt_w'(w_push) - c_cnt_w'(w_load);
            r_count   <= r_count + c_cnt_w'(w_push) - c_cnt_w'(w_pop);
        end
    end

    assign o_rd_data  = r_dout;
    assign o_rd_valid = r_valid;
    assign o_full     = w_full;
    assign o_empty    = (r_count == '0);
    assign o_count    = r_count;

endmodule

`default_nettype wire

// File: rtl/gps_iq_packer.sv
// ============================================================================
// Module      : gps_iq_packer
// Description : Packs five 3-bit I/Q samples plus a 2-bit sequence tag into
//               32-bit words and streams them out through a FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module gps_iq_packer
    import gps_pkg::*;
#(
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          enable,
    input  logic [SAMPLE_W-1:0]           real_in,
    input  logic [SAMPLE_W-1:0]           imag_in,
    output logic [WORD_W-1:0]             m_data,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fill_level,
    output logic [15:0]                   ovf_count,
    input  logic                          ovf_clr
);

    localparam logic [2:0]  c_last_lane = 3'(LANES_PER_WORD - 1);
    localparam logic [15:0] c_ovf_max   = 16'hFFFF;

    iq_sample_t              w_sample;
    logic [PAYLOAD_W-1:0]    w_acc_next;
    logic [2:0]              r_lane;
    logic [PAYLOAD_W-1:0]    r_acc;
    logic [SEQ_W-1:0]        r_seq;
    logic [WORD_W-1:0]       r_pack_word;
    logic                    r_pack_valid;
    logic [15:0]             r_ovf;

    logic w_fifo_full;
    logic w_fifo_empty;
    logic w_pop;
    logic w_drop;

    always_comb begin
        w_sample.real_part = real_in;
        w_sample.imag_part = imag_in;
        w_acc_next         = r_acc;
        for (int k = 0; k < LANES_PER_WORD; k++) begin
            if (r_lane == 3'(k)) begin
                w_acc_next[k*LANE_W +: LANE_W] = w_sample;
            end
        end
    end

    // Lanes left over from an abandoned word are overwritten before reuse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_lane       <= '0;
            r_acc        <= '0;
            r_seq        <= '0;
            r_pack_word  <= '0;
            r_pack_valid <= 1'b0;
        end else begin
            r_pack_valid <= 1'b0;
            if (enable) begin
                r_acc <= w_acc_next;
                if (r_lane == c_last_lane) begin
                    r_lane       <= '0;
                    r_pack_word  <= {r_seq, w_acc_next};
                    r_pack_valid <= 1'b1;
                    r_seq        <= r_seq + SEQ_W'(1);
                end else begin
                    r_lane <= r_lane + 3'd1;
                end
            end else begin
                r_lane <= '0;
            end
        end
    end

    gps_sync_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_wr_en    (r_pack_valid),
        .i_wr_data  (r_pack_word),
        .i_rd_en    (m_ready),
        .o_rd_data  (m_data),
        .o_rd_valid (m_valid),
        .o_full     (w_fifo_full),
        .o_empty    (w_fifo_empty),
        .o_count    (fill_level)
    );

    assign w_pop  = m_valid & m_ready & ~w_fifo_empty;
    assign w_drop = r_pack_valid & w_fifo_full & ~w_pop;

    // Clear takes effect first, so a coincident drop is still counted.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ovf <= '0;
        end else if (ovf_clr) begin
            r_ovf <= w_drop ? 16'd1 : 16'd0;
        end else if (w_drop && (r_ovf != c_ovf_max)) begin
            r_ovf <= r_ovf + 16'd1;
        end
    end

    assign ovf_count = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_gps_iq_packer.sv
// ============================================================================
// Module      : tb_gps_iq_packer
// Description : Directed self-checking bench for gps_iq_packer.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_gps_iq_packer;

    localparam int FIFO_DEPTH = 16;

    logic        clk     = 1'b0;
    logic        rst_n   = 1'b0;
    logic        enable  = 1'b0;
    logic        m_ready = 1'b0;
    logic        ovf_clr = 1'b0;
    logic [2:0]  real_in = 3'd0;
    logic [2:0]  imag_in = 3'd0;
    logic [31:0] m_data;
    logic        m_valid;
    logic [4:0]  fill_level;
    logic [15:0] ovf_count;

    always #5 clk = ~clk;

    gps_iq_packer #(.FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .real_in    (real_in),
        .imag_in    (imag_in),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .fill_level (fill_level),
        .ovf_count  (ovf_count),
        .ovf_clr    (ovf_clr)
    );

    int          n_checks   = 0;
    int          n_pass     = 0;
    int          sample_idx = 0;
    int          buf_n      = 0;
    logic [1:0]  exp_seq    = 2'd0;
    logic [2:0]  buf_re [5];
    logic [2:0]  buf_im [5];
    logic [31:0] got_q [$];
    logic [31:0] cmp_q [$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [31:0] pack_word(input logic [1:0] seq);
        logic [31:0] w;
        w = '0;
        for (int k = 0; k < 5; k++) w[6*k +: 6] = {buf_im[k], buf_re[k]};
        w[31:30] = seq;
        return w;
    endfunction

    // A transfer happens at the coming edge when valid and ready are both high now.
    task automatic step();
        if (m_valid && m_ready) got_q.push_back(m_data);
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic en, input logic [2:0] r, input logic [2:0] im);
        enable  = en;
        real_in = r;
        imag_in = im;
        if (en) begin
            buf_re[buf_n] = r;
            buf_im[buf_n] = im;
            buf_n++;
            if (buf_n == 5) begin
                cmp_q.push_back(pack_word(exp_seq));
                exp_seq++;
                buf_n = 0;
            end
        end else begin
            buf_n = 0;
        end
        step();
    endtask

    task automatic drive_seq(input int n);
        for (int i = 0; i < n; i++) begin
            drive(1'b1, 3'(sample_idx), 3'(sample_idx * 5 + 2));
            sample_idx++;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 3'd0, 3'd0);
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        enable  = 1'b0;
        m_ready = 1'b0;
        ovf_clr = 1'b0;
        buf_n   = 0;
        exp_seq = 2'd0;
        got_q.delete();
        cmp_q.delete();
        step();
        rst_n = 1'b1;
    endtask

    task automatic drain();
        int t;
        t = 0;
        m_ready = 1'b1;
        while ((m_valid || fill_level != 0) && t < 300) begin
            step();
            t++;
        end
        chk("drain_bound", 32'(t < 300), 32'd1);
    endtask

    initial begin
        // Reset state and first-word latency.
        do_reset();
        chk("rst_valid", 32'(m_valid), 32'd0);
        chk("rst_data", m_data, 32'h0);
        chk("rst_fill", 32'(fill_level), 32'd0);
        chk("rst_ovf", 32'(ovf_count), 32'd0);
        m_ready = 1'b1;
        drive(1'b1, 3'b001, 3'b111);
        drive(1'b1, 3'b010, 3'b110);
        drive(1'b1, 3'b011, 3'b101);
        drive(1'b1, 3'b100, 3'b011);
        drive(1'b1, 3'b000, 3'b001);
        chk("t1_valid_e0", 32'(m_valid), 32'd0);
        idle(1);
        chk("t1_valid_e1", 32'(m_valid), 32'd0);
        idle(1);
        chk("t1_valid_e2", 32'(m_valid), 32'd1);
        chk("t1_data", m_data, 32'h0872_BCB9);
        chk("t1_fill", 32'(fill_level), 32'd1);
        idle(1);
        chk("t1_valid_after_pop", 32'(m_valid), 32'd0);
        chk("t1_fill_after_pop", 32'(fill_level), 32'd0);

        // Continuous stream, consumer always ready.
        do_reset();
        m_ready = 1'b1;
        drive_seq(50);
        idle(10);
        chk("t2_count", 32'(got_q.size()), 32'd10);
        for (int i = 0; i < 10; i++) begin
            chk("t2_word", (i < got_q.size()) ? got_q[i] : 32'hx, cmp_q[i]);
            chk("t2_tag", (i < got_q.size()) ? 32'(got_q[i][31:30]) : 32'hx, 32'(i % 4));
        end
        chk("t2_ovf", 32'(ovf_count), 32'd0);
        chk("t2_fill", 32'(fill_level), 32'd0);

        // Enable gap discards the partial word.
        do_reset();
        m_ready = 1'b1;
        drive_seq(3);
        idle(2);
        drive_seq(5);
        idle(10);
        chk("t3_count", 32'(got_q.size()), 32'd1);
        chk("t3_word", (got_q.size() > 0) ? got_q[0] : 32'hx, cmp_q[0]);
        chk("t3_tag", (got_q.size() > 0) ? 32'(got_q[0][31:30]) : 32'hx, 32'd0);

        // Overflow with a stalled consumer, then drain.
        do_reset();
        drive_seq(100);
        idle(4);
        chk("t4_fill", 32'(fill_level), 32'd16);
        chk("t4_ovf", 32'(ovf_count), 32'd4);
        chk("t4_valid_held", 32'(m_valid), 32'd1);
        chk("t4_data_held", m_data, cmp_q[0]);
        drain();
        chk("t4_drained", 32'(got_q.size()), 32'd16);
        for (int i = 0; i < 16; i++) begin
            chk("t4_word", (i < got_q.size()) ? got_q[i] : 32'hx, cmp_q[i]);
            chk("t4_tag", (i < got_q.size()) ? 32'(got_q[i][31:30]) : 32'hx, 32'(i % 4));
        end
        chk("t4_ovf_kept", 32'(ovf_count), 32'd4);
        got_q.delete();
        drive_seq(5);
        idle(5);
        chk("t4_next_count", 32'(got_q.size()), 32'd1);
        chk("t4_next_tag", (got_q.size() > 0) ? 32'(got_q[0][31:30]) : 32'hx, 32'd0);
        chk("t4_next_word", (got_q.size() > 0) ? got_q[0] : 32'hx, cmp_q[20]);

        // Push and pop together on a full FIFO; clear versus drop.
        do_reset();
        drive_seq(80);
        idle(3);
        chk("t5_fill_full", 32'(fill_level), 32'd16);
        drive_seq(5);
        m_ready = 1'b1;
        step();
        m_ready = 1'b0;
        idle(2);
        chk("t5_fill_same", 32'(fill_level), 32'd16);
        chk("t5_ovf_none", 32'(ovf_count), 32'd0);
        chk("t5_popped", (got_q.size() > 0) ? got_q[0] : 32'hx, cmp_q[0]);
        chk("t5_next_head", m_data, cmp_q[1]);
        drive_seq(5);
        idle(2);
        drive_seq(5);
        idle(2);
        chk("t5_ovf_two", 32'(ovf_count), 32'd2);
        drive_seq(5);
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        idle(1);
        chk("t5_clr_with_drop", 32'(ovf_count), 32'd1);
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        chk("t5_clr_alone", 32'(ovf_count), 32'd0);

        // Reset mid-operation flushes queue and partial word.
        do_reset();
        drive_seq(43);
        chk("t6_pre_fill", 32'(fill_level), 32'd8);
        do_reset();
        chk("t6_valid", 32'(m_valid), 32'd0);
        chk("t6_fill", 32'(fill_level), 32'd0);
        m_ready = 1'b1;
        drive_seq(5);
        idle(1);
        chk("t6_valid_e1", 32'(m_valid), 32'd0);
        idle(1);
        chk("t6_valid_e2", 32'(m_valid), 32'd1);
        chk("t6_tag", 32'(m_data[31:30]), 32'd0);
        chk("t6_word", m_data, cmp_q[0]);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
